// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the CPU bus arbiter slice.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUS_FETCH = 2'd1,
    BUS_DATA  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  localparam logic [3:0]  BE_WORD         = 4'b1111;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  // Word-align a byte address; the bus only ever sees word addresses.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & ADDR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/mips_bus_watchdog.sv
// Wait-state watchdog: counts stalled cycles of the current bus transaction
// and flags a timeout on the cycle the count would reach MAX_WAIT.
// MAX_WAIT = 0 disables it; MAX_WAIT must stay below 2**WAIT_W.
module mips_bus_watchdog
  import mips_bus_pkg::*;
#(
  parameter int MAX_WAIT = 0,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic waitrequest,
  output logic timeout
);

  localparam logic              ENABLE = (MAX_WAIT > 0);
  localparam logic [WAIT_W-1:0] LIMIT  = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  logic [WAIT_W-1:0] cnt;

  // Stall counter: cleared when a transaction is granted, counts stalled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (ENABLE && busy && waitrequest) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires on the MAX_WAIT-th consecutive stalled cycle of a transaction.
  assign timeout = ENABLE && busy && waitrequest && (cnt == LIMIT);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-port arbiter (instruction fetch / data load-store) in front of a single
// Avalon-MM master. One transaction at a time, round-robin on ties.
//
// Handshakes:
//   Requester side: a port raises req with stable addr/data and holds it until
//   its ack pulses for one cycle; rdata is valid while ack is high. A port whose
//   ack is high this cycle is not eligible, so a req held through the ack cycle
//   is never serviced twice.
//   Bus side: read/write and all command fields are held stable while
//   waitrequest=1; the transfer completes on the cycle waitrequest=0, and
//   readdata is sampled in that cycle.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int MAX_WAIT = 0,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        bus_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  dbg_state
);

  arb_state_t state_q, state_d;
  grant_t     last_q, last_d;

  logic f_elig, d_elig;
  logic grant_f, grant_d;
  logic busy, done, timeout, finish;

  logic [31:0] address_d, writedata_d, f_rdata_d, d_rdata_d;
  logic [3:0]  byteenable_d;
  logic        read_d, write_d, f_ack_d, d_ack_d, bus_error_d;

  assign f_elig    = f_req && !f_ack;
  assign d_elig    = d_req && !d_ack;
  assign busy      = (state_q != IDLE);
  assign done      = busy && !waitrequest;
  // done and timeout are exclusive: timeout needs waitrequest=1.
  assign finish    = done || timeout;
  assign dbg_state = state_q;

  mips_bus_watchdog #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .start       (grant_f || grant_d),
    .busy        (busy),
    .waitrequest (waitrequest),
    .timeout     (timeout)
  );

  // FSM state and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= GRANT_FETCH;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next state: arbitrate in IDLE, leave BUS_* on completion or timeout.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_f = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (f_elig && d_elig) begin
          if (last_q == GRANT_FETCH) grant_d = 1'b1;
          else                       grant_f = 1'b1;
        end else if (f_elig) begin
          grant_f = 1'b1;
        end else if (d_elig) begin
          grant_d = 1'b1;
        end
        if (grant_f) begin
          state_d = BUS_FETCH;
          last_d  = GRANT_FETCH;
        end else if (grant_d) begin
          state_d = BUS_DATA;
          last_d  = GRANT_DATA;
        end
      end
      BUS_FETCH, BUS_DATA: begin
        if (finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values: load the command on grant, drop it and ack on finish.
  always_comb begin
    address_d    = address;
    read_d       = read;
    write_d      = write;
    writedata_d  = writedata;
    byteenable_d = byteenable;
    f_rdata_d    = f_rdata;
    d_rdata_d    = d_rdata;
    f_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    bus_error_d  = bus_error;
    if (grant_f) begin
      address_d    = align_word(f_addr);
      read_d       = 1'b1;
      write_d      = 1'b0;
      byteenable_d = BE_WORD;
    end else if (grant_d) begin
      address_d    = align_word(d_addr);
      read_d       = !d_write;
      write_d      = d_write;
      byteenable_d = d_byteen;
      writedata_d  = d_wdata;
    end else if (finish) begin
      read_d  = 1'b0;
      write_d = 1'b0;
      if (timeout) bus_error_d = 1'b1;
      if (state_q == BUS_FETCH) begin
        f_ack_d   = 1'b1;
        f_rdata_d = timeout ? 32'h0000_0000 : readdata;
      end else begin
        d_ack_d = 1'b1;
        if (timeout)   d_rdata_d = 32'h0000_0000;
        else if (read) d_rdata_d = readdata;
      end
    end
  end

  // Registered bus command, acks, read data and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      address    <= address_d;
      read       <= read_d;
      write      <= write_d;
      writedata  <= writedata_d;
      byteenable <= byteenable_d;
      f_rdata    <= f_rdata_d;
      d_rdata    <= d_rdata_d;
      f_ack      <= f_ack_d;
      d_ack      <= d_ack_d;
      bus_error  <= bus_error_d;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level reference model.
module tb_mips_bus_arbiter;

  localparam int MAXW = 4;
  localparam int W    = 72;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_write, waitrequest;
  logic [31:0] f_addr, d_addr, d_wdata, readdata;
  logic [3:0]  d_byteen;
  logic        f_ack, d_ack, bus_error, read, write;
  logic [31:0] f_rdata, d_rdata, address, writedata;
  logic [3:0]  byteenable;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [0:0] exp_q[$];

  // Reference model: bus owner, stall count, expected acks and read data.
  bit          m_busy, m_own_d, m_last_d, m_err;
  int          m_stalls;
  logic [31:0] m_addr, m_wdata;
  logic        m_rd, m_wr;
  logic [3:0]  m_be;
  bit          e_f_ack, e_d_ack;
  logic [31:0] e_f_rdata, e_d_rdata;
  bit          saw_f_ack, saw_d_ack;

  mips_bus_arbiter #(.MAX_WAIT(MAXW), .WAIT_W(8)) dut (
    .clk (clk), .reset (reset),
    .f_req (f_req), .f_addr (f_addr), .f_ack (f_ack), .f_rdata (f_rdata),
    .d_req (d_req), .d_write (d_write), .d_addr (d_addr), .d_wdata (d_wdata),
    .d_byteen (d_byteen), .d_ack (d_ack), .d_rdata (d_rdata),
    .bus_error (bus_error), .address (address), .read (read), .write (write),
    .writedata (writedata), .byteenable (byteenable),
    .waitrequest (waitrequest), .readdata (readdata), .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy    = 0;
    m_own_d   = 0;
    m_last_d  = 0;
    m_err     = 0;
    m_stalls  = 0;
    m_addr    = '0;
    m_wdata   = '0;
    m_rd      = 0;
    m_wr      = 0;
    m_be      = '0;
    e_f_ack   = 0;
    e_d_ack   = 0;
    e_f_rdata = '0;
    e_d_rdata = '0;
    saw_f_ack = 0;
    saw_d_ack = 0;
  endtask

  task automatic model_finish(input bit abort);
    m_busy = 0;
    if (abort) m_err = 1;
    if (m_own_d) begin
      e_d_ack = 1;
      if (abort)     e_d_rdata = '0;
      else if (m_rd) e_d_rdata = readdata;
    end else begin
      e_f_ack   = 1;
      e_f_rdata = abort ? 32'h0 : readdata;
    end
  endtask

  // Called once per cycle at the negedge: compare, then advance the model.
  task automatic model_step();
    bit fe, de, take_d;
    chk("f_ack", W'(f_ack), W'(e_f_ack));
    chk("d_ack", W'(d_ack), W'(e_d_ack));
    chk("f_rdata", W'(f_rdata), W'(e_f_rdata));
    chk("d_rdata", W'(d_rdata), W'(e_d_rdata));
    chk("bus_error", W'(bus_error), W'(m_err));
    chk("rw_excl", W'(read & write), W'(0));
    saw_f_ack = f_ack;
    saw_d_ack = d_ack;
    fe = f_req && !e_f_ack;
    de = d_req && !e_d_ack;
    e_f_ack = 0;
    e_d_ack = 0;
    if (m_busy) begin
      chk("cmd", W'({address, read, write, writedata, byteenable}),
          W'({m_addr, m_rd, m_wr, m_wdata, m_be}));
      if (!waitrequest) begin
        model_finish(0);
      end else begin
        m_stalls++;
        if (MAXW > 0 && m_stalls >= MAXW) model_finish(1);
      end
    end else begin
      chk("idle_bus", W'({read, write}), W'(2'b00));
      if (fe || de) begin
        take_d   = de && (!fe || !m_last_d);
        m_busy   = 1;
        m_own_d  = take_d;
        m_last_d = take_d;
        m_stalls = 0;
        if (take_d) begin
          m_addr  = {d_addr[31:2], 2'b00};
          m_rd    = !d_write;
          m_wr    = d_write;
          m_be    = d_byteen;
          m_wdata = d_wdata;
        end else begin
          m_addr = {f_addr[31:2], 2'b00};
          m_rd   = 1;
          m_wr   = 0;
          m_be   = 4'hF;
        end
      end
    end
  endtask

  // One clock: check at the negedge, return at posedge+1 ready to drive.
  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    f_req = 0;
    d_req = 0;
    reset = 0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask

  // Withdraw requests and let any in-flight transaction finish (bounded).
  task automatic drain();
    f_req       = 0;
    d_req       = 0;
    waitrequest = 0;
    for (int i = 0; i < 8; i++) step();
  endtask

  initial begin
    reset = 0; f_req = 0; f_addr = '0; d_req = 0; d_write = 0; d_addr = '0;
    d_wdata = '0; d_byteen = '0; waitrequest = 0; readdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rw", W'({read, write}), W'(2'b00));
    chk("rst_addr", W'(address), W'(0));
    chk("rst_wdata_be", W'({writedata, byteenable}), W'(0));
    chk("rst_acks", W'({f_ack, d_ack}), W'(2'b00));
    chk("rst_rdata", W'({f_rdata, d_rdata}), W'(0));
    chk("rst_err", W'(bus_error), W'(0));
    chk("rst_state", W'(dbg_state), W'(0));
    reset = 1;

    // Single zero-wait fetch
    f_req = 1; f_addr = 32'h0000_1006; readdata = 32'hDEADBEEF; waitrequest = 0;
    step();
    chk("t1_cmd", W'({address, read, byteenable}), W'({32'h0000_1004, 1'b1, 4'hF}));
    step();
    chk("t1_ack", W'(f_ack), W'(1));
    chk("t1_rdata", W'(f_rdata), W'(32'hDEADBEEF));
    step();
    f_req = 0;

    // Store with three wait states
    readdata = 32'hA5A5_A5A5;
    d_req = 1; d_write = 1; d_addr = 32'h20; d_wdata = 32'h12345678; d_byteen = 4'b0011;
    waitrequest = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) waitrequest = 0;
      chk("t2_cmd", W'({write, read, address, writedata, byteenable}),
          W'({1'b1, 1'b0, 32'h20, 32'h12345678, 4'b0011}));
      step();
    end
    chk("t2_ack", W'(d_ack), W'(1));
    chk("t2_rdata_kept", W'(d_rdata), W'(0));
    step();
    d_req = 0; d_write = 0;

    // Tie after reset: data, fetch, data, fetch
    do_reset();
    readdata = 32'h55AA_1234; waitrequest = 0;
    f_addr = 32'h100; d_addr = 32'h200; d_write = 0; d_byteen = 4'hF;
    f_req = 1; d_req = 1;
    exp_q = {1'b1, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 24 && exp_q.size() > 0; c++) begin
      if (f_ack || d_ack) begin
        chk("t3_one_ack", W'(f_ack & d_ack), W'(0));
        chk("t3_order", W'(d_ack), W'(exp_q.pop_front()));
      end
      step();
    end
    chk("t3_served", W'(exp_q.size()), W'(0));
    drain();

    // Watchdog abort of a stuck load; error stays set afterwards
    d_req = 1; d_write = 0; d_addr = 32'h40; d_byteen = 4'hF; waitrequest = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t4_read", W'(read), W'(1));
      step();
    end
    chk("t4_read_drop", W'(read), W'(0));
    chk("t4_ack", W'(d_ack), W'(1));
    chk("t4_rdata", W'(d_rdata), W'(0));
    chk("t4_err", W'(bus_error), W'(1));
    drain();
    f_req = 1; f_addr = 32'h300; readdata = 32'h0BAD_F00D;
    step();
    step();
    chk("t4_fetch_ack", W'(f_ack), W'(1));
    drain();
    chk("t4_err_sticky", W'(bus_error), W'(1));

    // Asynchronous reset in the middle of a stalled fetch
    do_reset();
    f_req = 1; f_addr = 32'h400; waitrequest = 1;
    step();
    step();
    chk("t5_read", W'(read), W'(1));
    reset = 0;
    #1;
    chk("t5_async_drop", W'(read), W'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("t5_no_ack", W'(f_ack), W'(0));
    reset = 1; waitrequest = 0; readdata = 32'hCAFE_F00D;
    step();
    step();
    chk("t5_ack", W'(f_ack), W'(1));
    chk("t5_rdata", W'(f_rdata), W'(32'hCAFE_F00D));
    drain();

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      waitrequest = ($urandom_range(0, 9) < 5);
      readdata    = $urandom();
      if (f_req && saw_f_ack) f_req = 0;
      if (!f_req && $urandom_range(0, 2) == 0) begin
        f_req  = 1;
        f_addr = $urandom();
      end
      if (d_req && saw_d_ack) d_req = 0;
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req    = 1;
        d_write  = $urandom_range(0, 1) == 1;
        d_addr   = $urandom();
        d_wdata  = $urandom();
        d_byteen = 4'($urandom_range(1, 15));
      end
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the single Avalon memory-mapped master port of the CPU between two requesters: instruction fetch (read-only) and data load/store.
- Sits between the CPU core sequencer and the external bus.
- Runs one outstanding transaction at a time, holds it across waitrequest, returns read data with a one-cycle ack, and alternates grants fairly when both ports request.
- Has an optional watchdog that aborts transactions stalled too long by waitrequest.

Parameters:
- MAX_WAIT, 0, cycles waitrequest may stay high before abort; 0 disables the watchdog.
- WAIT_W, 8, width of the wait counter; MAX_WAIT must be below 2**WAIT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request; held high until f_ack.
- f_addr  in  32  fetch byte address.
- f_ack  out  1  one-cycle pulse: fetch complete.
- f_rdata  out  32  fetched word; valid while f_ack is high.
- d_req  in  1  data request; held high until d_ack.
- d_write  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_byteen  in  4  store/load byte enables.
- d_ack  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  load word; valid while d_ack is high.
- bus_error  out  1  sticky; set on a watchdog abort.
- address  out  32  Avalon address; bits [1:0] are always 0.
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- writedata  out  32  Avalon write data.
- byteenable  out  4  Avalon byte enables.
- waitrequest  in  1  Avalon stall.
- readdata  in  32  Avalon read data; valid in the cycle read=1 and waitrequest=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; read=write=0.
  - address, writedata, byteenable, f_rdata, d_rdata = 0.
  - f_ack=d_ack=0; bus_error=0; last_grant=FETCH; wait counter=0.
  - A reset during BUS_* drops read/write immediately, and the transaction is lost without an ack.
- States: IDLE, BUS_FETCH, BUS_DATA.
- IDLE:
  - Eligible fetch = f_req && !f_ack. Eligible data = d_req && !d_ack. The ack mask prevents re-granting a requester in the cycle it is dropping req.
  - Only one eligible: grant it.
  - Both eligible: grant the port not equal to last_grant (round-robin). After reset, data wins the first tie.
  - On grant, registered at that edge:
    - address = addr with [1:0] cleared.
    - Fetch grant: read=1, byteenable=4'b1111.
    - Data grant: read=!d_write, write=d_write, byteenable=d_byteen, writedata=d_wdata.
    - last_grant is updated; next state is BUS_FETCH or BUS_DATA.
  - Latency: req sampled at edge N puts the bus command on the bus during cycle N+1.
- BUS_*, all bus outputs held stable while waitrequest=1.
  - Edge with waitrequest=0: completes the transaction.
    - Drop read/write; return to IDLE.
    - Pulse the owner's ack for exactly one cycle.
    - If the transaction was a read, capture readdata into the owner's rdata.
    - Stores ack without changing d_rdata.
  - Minimum transaction cost with zero wait states: grant edge, then complete edge, so ack is seen 2 cycles after req.
  - The IDLE cycle that carries the ack may grant the other port. Back-to-back service of alternating ports therefore needs no dead cycle.
- Watchdog (MAX_WAIT>0):
  - The counter increments on each waitrequest=1 cycle in BUS_* and clears on entry to BUS_*.
  - When the counter reaches MAX_WAIT with waitrequest still 1:
    - Drop read/write; set bus_error; go to IDLE.
    - Pulse the owner's ack; rdata is forced to 32'h0000_0000.
  - bus_error clears only on reset.
- f_rdata and d_rdata hold their last value between acks.
- Never assert read and write together; never assert both acks in the same cycle.

Decomposition:
- Package mips_bus_pkg:
  - enum arb_state_t {IDLE, BUS_FETCH, BUS_DATA}.
  - enum grant_t {GRANT_FETCH, GRANT_DATA}.
  - Constant BE_WORD = 4'b1111.
  - Constant ADDR_ALIGN_MASK = 32'hFFFF_FFFC.
- One natural sub-module, mips_bus_watchdog: wait counter plus timeout compare, parameterised by MAX_WAIT and WAIT_W.
- The arbiter FSM and bus registers stay in the top module.

Test Plan:
- Fetch only, f_addr=32'h0000_1006, waitrequest=0, readdata=32'hDEADBEEF -> address=32'h0000_1004, read=1, byteenable=4'hF for 1 cycle; f_ack pulses with f_rdata=32'hDEADBEEF 2 cycles after req.
- Store, d_addr=32'h20, d_wdata=32'h12345678, d_byteen=4'b0011, waitrequest high 3 cycles -> write=1 and outputs stable for 4 cycles; d_ack after; d_rdata unchanged.
- f_req and d_req raised together after reset, each re-raised after its ack -> grant order data, fetch, data, fetch; no cycle with read&write; one ack per transaction.
- MAX_WAIT=4, data load with waitrequest stuck high -> read drops after 4 stall cycles; d_ack=1, d_rdata=0, bus_error=1, which stays 1 through later good transactions.
- Reset asserted mid-fetch with waitrequest=1 -> read=0 immediately (asynchronously); no f_ack; after release, a new fetch completes normally.
- Load while fetch acks in the same IDLE cycle -> data granted that cycle; fetch not re-granted while f_ack=1.
